// File: rtl/nibble_ser_sched_pkg.sv
// Shared state type, default sizing and the round-robin pick helper
// used by the nibble serialiser scheduler and its grant logic.
package nibble_ser_pkg;

  localparam int DEF_NREQ = 2;
  localparam int DEF_W    = 4;
  localparam int DEF_IDW  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // First set bit of valid at or after ptr, wrapping modulo nreq (nreq <= 4).
  function automatic logic [1:0] rr_index(input logic [3:0] valid,
                                          input logic [1:0] ptr,
                                          input logic [2:0] nreq);
    logic [1:0] idx;
    logic       found;
    logic [2:0] cand;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = 3'(ptr) + 3'(i);
      if (cand >= nreq) begin
        cand = cand - nreq;
      end else begin
        cand = cand;
      end
      if (!found && (3'(i) < nreq) && valid[cand[1:0]]) begin
        idx   = cand[1:0];
        found = 1'b1;
      end else begin
        idx   = idx;
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/nibble_ser_sched_if.sv
// Requester bus plus serial lane of the nibble serialiser scheduler.
// master = producer/consumer side, slave = the scheduler.
interface nibble_ser_sched_if
  import nibble_ser_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  parameter int IDW  = DEF_IDW
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              dout;
  logic              dout_valid;
  logic              dout_sof;
  logic [IDW-1:0]    dout_src;
  logic              busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, dout, dout_valid, dout_sof, dout_src, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, dout, dout_valid, dout_sof, dout_src, busy
  );
endinterface

// File: rtl/nibble_ser_sched_rr_grant.sv
// Combinational round-robin grant: one-hot grant and index of the first
// valid requester at or after ptr, suppressed when en is low.
module rr_grant
  import nibble_ser_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = DEF_IDW
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [3:0] valid_s;
  logic [1:0] idx_s;
  logic       any_s;

  // Round-robin search and one-hot expansion
  always_comb begin
    valid_s              = 4'd0;
    valid_s[NREQ-1:0]    = req_valid;
    idx_s                = rr_index(valid_s, 2'(ptr), 3'(NREQ));
    any_s                = en & (|req_valid);
    grant                = {NREQ{1'b0}};
    if (any_s) begin
      grant_idx = IDW'(idx_s);
    end else begin
      grant_idx = {IDW{1'b0}};
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = any_s && (idx_s == 2'(i));
    end
  end

endmodule

// File: rtl/nibble_ser_sched.sv
// Round-robin scheduler sharing one LSB-first serial lane between NREQ
// nibble producers; the next word is taken in the last-bit cycle for zero gap.
module nibble_ser_sched
  import nibble_ser_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  parameter int IDW  = DEF_IDW
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_ser_sched_if.slave bus
);

  localparam int             CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(W - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  state_e          state_r;
  state_e          state_s;
  logic [CW-1:0]   cnt_r;
  logic [IDW-1:0]  ptr_r;
  logic [W-1:0]    sh_r;
  logic            dout_r;
  logic            dout_valid_r;
  logic            dout_sof_r;
  logic [IDW-1:0]  dout_src_r;
  logic            window_s;
  logic            xfer_s;
  logic            busy_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  gidx_s;
  logic [W-1:0]    word_s;

  rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
    .req_valid (bus.req_valid),
    .ptr       (ptr_r),
    .en        (window_s),
    .grant     (grant_s),
    .grant_idx (gidx_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: stay in SHIFT across back-to-back words
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) state_s = SHIFT;
        else        state_s = IDLE;
      end
      SHIFT: begin
        if ((cnt_r != LAST) || xfer_s) state_s = SHIFT;
        else                           state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: accept window and busy, both forced low during reset
  always_comb begin
    busy_s = rst_n & (state_r == SHIFT);
    if (!rst_n) begin
      window_s = 1'b0;
    end else if (state_r == IDLE) begin
      window_s = 1'b1;
    end else begin
      window_s = (cnt_r == LAST);
    end
  end

  // Select the granted requester's word
  always_comb begin
    word_s = {W{1'b0}};
    xfer_s = |grant_s;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) word_s = bus.req_data[i*W +: W];
      else            word_s = word_s;
    end
  end

  // Shift register, bit counter, pointer and registered lane outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_r         <= {W{1'b0}};
      cnt_r        <= {CW{1'b0}};
      ptr_r        <= {IDW{1'b0}};
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      dout_sof_r   <= 1'b0;
      dout_src_r   <= {IDW{1'b0}};
    end else if (xfer_s) begin
      sh_r         <= word_s;
      cnt_r        <= {CW{1'b0}};
      ptr_r        <= (gidx_s == LAST_ID) ? {IDW{1'b0}} : gidx_s + IDW'(1);
      dout_r       <= word_s[0];
      dout_valid_r <= 1'b1;
      dout_sof_r   <= 1'b1;
      dout_src_r   <= gidx_s;
    end else if ((state_r == SHIFT) && (cnt_r != LAST)) begin
      sh_r         <= {1'b0, sh_r[W-1:1]};
      cnt_r        <= cnt_r + CW'(1);
      dout_r       <= sh_r[1];
      dout_sof_r   <= 1'b0;
    end else if (state_r == SHIFT) begin
      cnt_r        <= {CW{1'b0}};
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      dout_sof_r   <= 1'b0;
    end else begin
      sh_r         <= sh_r;
      cnt_r        <= cnt_r;
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.dout_sof   = dout_sof_r;
  assign bus.dout_src   = dout_src_r;
  assign bus.busy       = busy_s;

endmodule
